// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: shared shift-add / restoring-divide datapath
// driven by a four-state controller with a fixed XLEN+2 cycle latency for every op.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic                r_sa, r_sb, r_bzero;
  logic [XLEN-1:0]     r_ma, r_mb;
  logic [2*XLEN-1:0]   r_acc;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_result;
  logic                r_busy, r_done;

  logic                w_a_sgn, w_b_sgn;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_acc;
  logic [XLEN:0]       w_rem_sh, w_rem_sub;
  logic                w_ge;
  logic [2*XLEN-1:0]   w_div_acc;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo, w_rem, w_fix;

  assign w_a_sgn = a[XLEN-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign w_b_sgn = b[XLEN-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign w_a_mag = w_a_sgn ? -a : a;
  assign w_b_mag = w_b_sgn ? -b : b;

  // Multiply: add into the upper half, then shift the whole product right one bit.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_mb[0] ? r_ma : '0)};
  assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: remainder lives in the upper half, quotient bits enter the lower half.
  assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_ma[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_mb});
  assign w_rem_sub = w_rem_sh - {1'b0, r_mb};
  assign w_div_acc = {(w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix = '0;
    case (r_op)
      OP_MUL:          w_fix = w_prod[XLEN-1:0];
      OP_DIV, OP_DIVU: w_fix = r_bzero ? '1 : w_quo;
      OP_REM, 3'b111:  w_fix = w_rem;  // |a| with a's sign restored is a itself when b==0
      default:         w_fix = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_bzero  <= 1'b0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_sa    <= w_a_sgn;
            r_sb    <= w_b_sgn;
            r_bzero <= (b == '0);
            r_ma    <= w_a_mag;
            r_mb    <= w_b_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (r_op[2]) begin
            r_acc <= w_div_acc;
            r_ma  <= r_ma << 1;
          end else begin
            r_acc <= w_mul_acc;
            r_mb  <= r_mb >> 1;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed RV32M results, fixed latency,
// back-to-back issue, ignored starts, operand stability and asynchronous reset.
module tb_mdu_sequencer;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;  // edges after the accepting edge until done is seen

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, wait for done, check latency/result, return in IDLE.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, LAT);
    check({tag, "_res"}, result, exp);
    check({tag, "_excl"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b1; op = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("mul_7x-3",   3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulh_m1x2",  3'b001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    do_op("div_-7/2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    do_op("rem_-7/2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    do_op("div_7/-2",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    do_op("rem_7/-2",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1);
    do_op("divu_100/7", 3'b101, 32'd100,       32'd7,         32'd14);
    do_op("remu_100/7", 3'b111, 32'd100,       32'd7,         32'd2);
    do_op("divu_by0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
    do_op("remu_by0",   3'b111, 32'd5,         32'd0,         32'd5);
    do_op("div_neg_by0",3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF);
    do_op("rem_neg_by0",3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);
    do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // start held high: second op accepted XLEN+3 cycles after the first
    op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_res", result, 32'd15);
    b = 32'd6;
    @(posedge clk); #1;
    check("b2b_done_width", {31'd0, done}, 32'd0);
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_interval", n, XLEN + 3);
    check("b2b_second_res", result, 32'd18);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_idle", {31'd0, busy}, 32'd0);

    // inputs changed and start re-pulsed while busy
    op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = 3'b000; a = 32'd1234; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 6;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("midop_lat", n, LAT);
    check("midop_res", result, 32'd14);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_start_ignored", {31'd0, busy}, 32'd0);

    // asynchronous reset during ITER
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst_mul", 3'b000, 32'd3, 32'd4, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
